// File: rtl/sp_ram_be.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_be
//  Description : Single-port synchronous RAM with per-byte write enables,
//                selectable read-during-write behaviour, optional output
//                register and a built-in zeroing sweep after reset or clr.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    req,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    init_busy
);

    localparam int                    c_DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                    c_NBYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    // Reject widths that cannot be split into bytes and unknown RDW modes.
    if (((DATA_WIDTH % 8) != 0) || (RDW_MODE < 0) || (RDW_MODE > 2)) begin : g_param_check
        $error("sp_ram_be: DATA_WIDTH must be a multiple of 8 and RDW_MODE must be 0..2");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_next;

    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_accept;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    logic                    w_resp_valid;
    logic [DATA_WIDTH-1:0]   w_resp_data;
    logic                    r_s1_valid;
    logic [DATA_WIDTH-1:0]   r_s1_data;

    assign ready     = (r_state == ST_RUN);
    assign init_busy = (r_state == ST_INIT);

    // clr takes priority over a same-cycle request, so the request is dropped.
    assign w_accept  = req && ready && !clr;
    assign w_rd_word = r_mem[addr];

    for (genvar i = 0; i < c_NBYTES; i++) begin : g_byte_merge
        assign w_merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : w_rd_word[8*i +: 8];
    end

    // The sweep owns the write port while initialising.
    assign w_mem_we    = init_busy || (w_accept && we);
    assign w_mem_addr  = init_busy ? r_cnt : addr;
    assign w_mem_wdata = init_busy ? '0 : w_merged;

    // State register and sweep counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: sweep DEPTH words, then serve; clr restarts the sweep.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (clr) begin
                    w_cnt_next = '0;
                end else if (r_cnt == c_LAST_ADDR) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    w_state_next = ST_INIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Storage array; contents are cleared by the sweep, not by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Response selection: reads return the stored word, writes follow RDW_MODE.
    always_comb begin
        w_resp_valid = 1'b0;
        w_resp_data  = w_rd_word;
        if (w_accept) begin
            if (!we) begin
                w_resp_valid = 1'b1;
            end else if (RDW_MODE == 0) begin
                w_resp_valid = 1'b1;
            end else if (RDW_MODE == 1) begin
                w_resp_valid = 1'b1;
                w_resp_data  = w_merged;
            end
        end
    end

    // First response stage; data only moves on a valid response so it holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_resp_valid;
            if (w_resp_valid) begin
                r_s1_data <= w_resp_data;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_s2_valid;
        logic [DATA_WIDTH-1:0] r_s2_data;

        // Second response stage, shifting every cycle with no back-pressure.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_s2_valid <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign rvalid = r_s2_valid;
        assign rdata  = r_s2_data;
    end else begin : g_no_out_reg
        assign rvalid = r_s1_valid;
        assign rdata  = r_s1_data;
    end

endmodule
`default_nettype wire

// File: doc/sp_ram_be.md
Name: sp_ram_be

Overview:
Parametrised single-port synchronous RAM with per-byte write enables, selectable read-during-write mode and an optional output register. After reset, or on request, a built-in init sequencer sweeps the array to zero. A req/ready handshake and an rvalid output let it serve as the generic local storage block for datapath and buffer designs.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 4, address width; DEPTH = 2**ADDR_WIDTH words
RDW_MODE, 0, read-during-write mode: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
clr  in  1  synchronous request to re-zero the whole array
req  in  1  access request, qualified by ready
we  in  1  1 = write, 0 = read
be  in  DATA_WIDTH/8  byte enables for writes; bit i covers wdata[8i+7:8i]
addr  in  ADDR_WIDTH  word address
wdata  in  DATA_WIDTH  write data
ready  out  1  block can accept a request this cycle
rdata  out  DATA_WIDTH  read data
rvalid  out  1  one-cycle pulse when rdata holds a response
init_busy  out  1  high while the zeroing sweep runs

Behaviour:
- Reset (async, active-low): FSM goes to INIT and the init counter goes to 0. Outputs: ready=0, rvalid=0, rdata=0, init_busy=1. Pipeline registers are cleared. Array contents are not reset directly; the INIT sweep clears them.
- FSM states are INIT and RUN.
- INIT:
  - Writes zero to address cnt each cycle, then increments cnt.
  - After writing DEPTH-1, moves to RUN on the next edge. The sweep takes exactly DEPTH cycles.
  - ready=0 and init_busy=1 throughout. req is ignored.
- RUN: ready=1 and init_busy=0. clr=1 returns the FSM to INIT with cnt=0.
- clr asserted during INIT restarts the sweep from address 0.
- clr=1 together with an accepted req in the same cycle: clr wins and the request is dropped (not executed, no rvalid).
- Accept condition: req && ready.
- Write (we=1):
  - For each i, the mem[addr] byte i is replaced by the wdata byte i when be[i]=1, and unchanged when be[i]=0.
  - be=0 is a legal no-op write.
- Read (we=0): rdata=mem[addr] with rvalid=1, exactly L cycles after acceptance (L=1+OUT_REG).
- Write response by RDW_MODE, delivered at the same latency L:
  - READ_FIRST: rdata = word before the write, rvalid=1.
  - WRITE_FIRST: rdata = merged post-write word, rvalid=1.
  - NO_CHANGE: rdata holds its previous value, rvalid=0.
- Back-to-back: one request accepted per cycle with full throughput.
  - A read issued the cycle after a write to the same address returns the post-write word.
- rdata holds its last value when rvalid=0. It never returns X after reset.
- With OUT_REG=1, both stages shift every cycle; there is no back-pressure.
- Async reset mid-operation aborts any in-flight response (rvalid=0) and restarts INIT.
- Address wrap: ADDR_WIDTH bits index exactly DEPTH words. No out-of-range addresses exist.
- Invalid parameters: DATA_WIDTH not a multiple of 8, or RDW_MODE > 2, is a compile-time error (elaboration check).

Test Plan:
- Release reset, DEPTH=16 -> init_busy=1 and ready=0 for 16 cycles, then ready=1; reads of addresses 0..15 all return 0x00000000 with rvalid exactly 1 cycle later.
- Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x11223344 to addr 3 with be=4'b0101 -> read of addr 3 returns 0xDE22BE44.
- RDW_MODE=0: mem[5]=0xAAAAAAAA, write 0x55555555 to addr 5 -> rdata=0xAAAAAAAA, rvalid=1. RDW_MODE=1: same stimulus -> rdata=0x55555555. RDW_MODE=2: same stimulus -> rvalid=0 and rdata unchanged.
- OUT_REG=1: reads of addrs 1,2,3 on consecutive cycles -> rvalid high on cycles +2,+3,+4 with the matching data, no bubbles.
- After filling memory, pulse clr with a same-cycle read req -> no rvalid for that read, 16-cycle sweep, then every address reads 0; a second clr midway through the sweep extends it to a full 16 cycles from that point.
- Assert reset 1 cycle after a read is accepted with OUT_REG=1 -> rvalid never pulses, rdata=0, and the INIT sweep restarts after reset is released.
